// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side sequencer for a registered-read block RAM.
// Walks base_addr .. base_addr+length-1 on the RAM read port, absorbs the
// one-cycle read latency and streams the words out over valid/ready through
// a two-entry output buffer.
// Optional build macro RAM_STREAM_READER_STRIDE_EN adds a per-transfer
// address stride port; without it the address step is fixed at 1.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
`ifdef RAM_STREAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;

  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  issued_cnt;
  logic [LEN_WIDTH-1:0]  delivered_cnt;
  logic [ADDR_WIDTH-1:0] step;
  logic                  accept;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic [1:0]            occ;

  // Read issued last cycle; its data is on ram_rd this cycle.
  logic                  vld_p1;
  logic                  last_p1;

  // Two-entry output buffer; entry 0 is the word being presented.
  logic [DATA_WIDTH-1:0] buf0_data, buf1_data;
  logic                  buf0_last, buf1_last;
  logic [1:0]            buf_cnt;

`ifdef RAM_STREAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_reg;

  // Stride is a per-transfer setting captured with the start command.
  always_ff @(posedge clk) begin
    if (start && (state == S_IDLE)) begin
      stride_reg <= stride;
    end
  end

  assign step = stride_reg;
`else
  assign step = ADDR_WIDTH'(1);
`endif

  assign accept     = (state == S_IDLE) && start;
  assign pop        = out_valid && out_ready;
  // A word leaving this cycle frees its slot for a read issued this cycle,
  // which is what keeps the stream at one word per cycle.
  assign occ        = buf_cnt - {1'b0, pop} + {1'b0, vld_p1};
  assign issue_last = (issued_cnt == len_reg - LEN_WIDTH'(1));
  assign issue      = (state == S_READ) && (occ < 2'd2);

  assign out_valid  = (buf_cnt != 2'd0);
  assign out_data   = buf0_data;
  assign out_last   = buf0_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy = 1'b1;
        if (issue && issue_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && (delivered_cnt == len_reg - LEN_WIDTH'(1))) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address walk, issue/delivery counters and the in-flight read stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg       <= '0;
      issued_cnt    <= '0;
      delivered_cnt <= '0;
      ram_r_addr    <= '0;
      vld_p1        <= 1'b0;
      last_p1       <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue && issue_last;
      if (accept) begin
        len_reg       <= length;
        issued_cnt    <= '0;
        delivered_cnt <= '0;
        ram_r_addr    <= base_addr;
      end else begin
        if (issue) begin
          issued_cnt <= issued_cnt + LEN_WIDTH'(1);
          // After the final issue the address stays on the last word read.
          if (!issue_last) begin
            ram_r_addr <= ram_r_addr + step;
          end
        end
        if (pop) begin
          delivered_cnt <= delivered_cnt + LEN_WIDTH'(1);
        end
      end
    end
  end

  // Output buffer: capture returning RAM data, shift forward on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_data <= '0;
      buf1_data <= '0;
      buf0_last <= 1'b0;
      buf1_last <= 1'b0;
      buf_cnt   <= 2'd0;
    end else begin
      case ({vld_p1, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf0_data <= ram_rd;
            buf0_last <= last_p1;
          end else begin
            buf1_data <= ram_rd;
            buf1_last <= last_p1;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0_data <= buf1_data;
          buf0_last <= buf1_last;
          buf_cnt   <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0_data <= ram_rd;
            buf0_last <= last_p1;
          end else begin
            buf0_data <= buf1_data;
            buf0_last <= buf1_last;
            buf1_data <= ram_rd;
            buf1_last <= last_p1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench for ram_stream_reader with a
// transfer-level reference model (expected word queue built at start).
`timescale 1ns/1ps
module tb_ram_stream_reader;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_rd;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
`ifdef RAM_STREAM_READER_STRIDE_EN
  logic [AW-1:0] stride;
`endif

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .length(length),
`ifdef RAM_STREAM_READER_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy),
    .done(done),
    .ram_r_addr(ram_r_addr),
    .ram_rd(ram_rd),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  // RAM contents: ram[i] = i + 100, registered read.
  always @(posedge clk) ram_rd <= ram_r_addr + 32'd100;

  // Reference model state
  logic [DW:0]   exp_q[$];
  bit            m_idle = 1'b1;
  bit            m_done_now = 1'b0;
  bit            m_stall = 1'b0;
  logic [DW-1:0] m_prev_data;
  logic          m_prev_last;
  int            hs_count = 0;
  int            checks = 0;
  int            errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] cur_stride();
`ifdef RAM_STREAM_READER_STRIDE_EN
    return stride;
`else
    return 32'd1;
`endif
  endfunction

  // Per-cycle compare against the model, then advance the model by one edge.
  task automatic model_cycle();
    logic [DW:0]   head;
    logic [AW-1:0] a;
    bit            hs;
    bit            next_done;
    chk("done", done, m_done_now);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", out_valid, 1'b0);
      end else begin
        head = exp_q[0];
        chk("out_data", out_data, head[DW-1:0]);
        chk("out_last", out_last, head[DW]);
      end
    end
    if (m_stall) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, m_prev_data);
      chk("stall_last", out_last, m_prev_last);
    end
    assert (dut.buf_cnt <= 2'd2) else begin
      errors++;
      $display("FAIL buffer_overflow: count %0d", dut.buf_cnt);
    end
    hs          = out_valid && out_ready;
    m_stall     = out_valid && !out_ready;
    m_prev_data = out_data;
    m_prev_last = out_last;
    next_done   = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_idle     = 1'b1;
      m_done_now = 1'b0;
      m_stall    = 1'b0;
      return;
    end
    if (hs && exp_q.size() != 0) begin
      head = exp_q.pop_front();
      hs_count++;
      if (head[DW]) next_done = 1'b1;
    end
    if (m_idle && start) begin
      for (int k = 0; k < int'(length); k++) begin
        a = base_addr + AW'(k) * cur_stride();
        exp_q.push_back({(k == int'(length) - 1), a + 32'd100});
      end
      if (length == '0) next_done = 1'b1;
      m_idle = 1'b0;
    end
    if (m_done_now) m_idle = 1'b1;
    m_done_now = next_done;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    bit seen = 1'b0;
    for (int p = 0; p < budget; p++) begin
      if (toggle) out_ready = ((p % 4) == 0) || ((p % 4) == 3);
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("done_seen", seen, 1'b1);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] n);
    base_addr = b;
    length    = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int h0;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
`ifdef RAM_STREAM_READER_STRIDE_EN
    stride = 32'd1;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_addr", ram_r_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic transfer, consumer always ready
    out_ready = 1'b1;
    do_start(32'd4, 16'd8);                       // now S+1
    chk("t1_busy", busy, 1'b1);
    chk("t1_addr0", ram_r_addr, 32'd4);
    chk("t1_novalid1", out_valid, 1'b0);
    tick();                                       // S+2
    chk("t1_addr1", ram_r_addr, 32'd5);
    chk("t1_novalid2", out_valid, 1'b0);
    tick();                                       // S+3
    chk("t1_first_valid", out_valid, 1'b1);
    chk("t1_first_data", out_data, 32'd104);
    for (int i = 0; i < 7; i++) tick();           // S+10
    chk("t1_last_data", out_data, 32'd111);
    chk("t1_last_flag", out_last, 1'b1);
    tick();                                       // S+11
    chk("t1_done", done, 1'b1);
    chk("t1_busy_done", busy, 1'b0);
    tick();
    chk("t1_done_once", done, 1'b0);
    chk("t1_q_empty", exp_q.size(), 0);
    tick();

    // Same transfer, ready pattern 1,0,0,1
    h0 = hs_count;
    do_start(32'd4, 16'd8);
    run_until_done(80, 1'b1);
    chk("t2_count", hs_count - h0, 8);
    chk("t2_q_empty", exp_q.size(), 0);
    out_ready = 1'b1;
    tick();
    tick();

    // Zero length
    do_start(32'd7, 16'd0);                       // S+1
    chk("t3_done", done, 1'b1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_valid", out_valid, 1'b0);
    tick();
    chk("t3_done_once", done, 1'b0);
    tick();

    // Address wrap-around
    do_start(32'hFFFF_FFFE, 16'd4);               // S+1
    chk("t4_addr0", ram_r_addr, 32'hFFFF_FFFE);
    tick();
    chk("t4_addr1", ram_r_addr, 32'hFFFF_FFFF);
    tick();                                       // S+3
    chk("t4_addr2", ram_r_addr, 32'h0000_0000);
    chk("t4_data0", out_data, 32'h62);
    tick();
    chk("t4_addr3", ram_r_addr, 32'h0000_0001);
    tick();
    chk("t4_addr_hold", ram_r_addr, 32'h0000_0001);
    run_until_done(20, 1'b0);
    tick();
    tick();

    // Long stall fills the buffer
    do_start(32'd20, 16'd5);                      // S+1
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();           // S+6
    chk("t5_stall_valid", out_valid, 1'b1);
    chk("t5_stall_data", out_data, 32'd120);
    out_ready = 1'b1;
    run_until_done(20, 1'b0);
    chk("t5_q_empty", exp_q.size(), 0);
    tick();
    tick();

    // Reset mid-transfer after 3 words
    do_start(32'd4, 16'd8);                       // S+1
    for (int i = 0; i < 5; i++) tick();           // S+6
    chk("t6_pre_data", out_data, 32'd107);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();                                       // S+7
    rst = 1'b0;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_addr", ram_r_addr, 32'd0);
    chk("t6_data", out_data, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t6_no_done", done, 1'b0);
    chk("t6_idle_valid", out_valid, 1'b0);
    do_start(32'd0, 16'd2);                       // S'+1
    tick();
    tick();                                       // S'+3
    chk("t6_w0", out_data, 32'd100);
    chk("t6_w0_last", out_last, 1'b0);
    tick();
    chk("t6_w1", out_data, 32'd101);
    chk("t6_w1_last", out_last, 1'b1);
    tick();
    chk("t6_done_after", done, 1'b1);
    tick();
    tick();

`ifdef RAM_STREAM_READER_STRIDE_EN
    // Strided walk
    stride = 32'd3;
    do_start(32'd0, 16'd4);                       // S+1
    chk("t7_addr0", ram_r_addr, 32'd0);
    tick();
    chk("t7_addr1", ram_r_addr, 32'd3);
    tick();
    chk("t7_addr2", ram_r_addr, 32'd6);
    chk("t7_data0", out_data, 32'd100);
    tick();
    chk("t7_addr3", ram_r_addr, 32'd9);
    chk("t7_data1", out_data, 32'd103);
    run_until_done(20, 1'b0);
    tick();
    tick();
    stride = 32'd1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
